inst_fetch: RTL and testbench

- Instruction-fetch stage; consumes the `pc_o`/`sending` stream produced by the PC register and throttles it with `stall0`.
- Reads each 32-bit instruction from byte-wide shared RAM as four little-endian byte reads, via the memory arbiter (`mem_grant`).
- Presents the instruction plus its PC to IF/ID; aborts on branch redirect `br`.

---
 rtl/inst_fetch.sv | 156 +++++++++++++++
 tb/tb_inst_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: four byte reads per word via arbiter; optional I-cache under ICACHE_EN
module inst_fetch #(
  parameter int ICACHE_INDEX_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sending,
  input  logic [31:0] pc_i,
  input  logic        br,
  output logic        stall0,
  input  logic        stall_in,
  output logic        ram_req_o,
  output logic [31:0] ram_addr_o,
  input  logic        mem_grant,
  input  logic [7:0]  ram_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_base;
  logic [2:0]  r_issue_cnt;
  logic [1:0]  r_recv_cnt;
  logic        r_rd_pending;
  logic [23:0] r_word;
  logic        w_accept;
  logic        w_complete;
  logic        w_grant;
  logic        w_hit;
  logic [31:0] w_line;

  assign w_grant = ram_req_o & mem_grant;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_INDEX_W;
  localparam int TAG_W = 30 - ICACHE_INDEX_W;

  logic [LINES-1:0]          r_cv;
  logic [TAG_W-1:0]          r_ctag  [LINES];
  logic [31:0]               r_cdata [LINES];
  logic [ICACHE_INDEX_W-1:0] w_idx;
  logic [ICACHE_INDEX_W-1:0] w_fill_idx;

  assign w_idx      = pc_i[ICACHE_INDEX_W+1:2];
  assign w_fill_idx = r_base[ICACHE_INDEX_W+1:2];
  assign w_hit      = r_cv[w_idx] && (r_ctag[w_idx] == pc_i[31:ICACHE_INDEX_W+2]);
  assign w_line     = r_cdata[w_idx];

  // line valid bits: cleared by reset, set when a fetch completes without a redirect
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cv <= '0;
    end else if (!br && w_complete) begin
      r_cv[w_fill_idx] <= 1'b1;
    end
  end

  // line tag/data fill on completion
  always_ff @(posedge clock) begin
    if (!reset && !br && w_complete) begin
      r_ctag[w_fill_idx]  <= r_base[31:ICACHE_INDEX_W+2];
      r_cdata[w_fill_idx] <= {ram_data_i, r_word};
    end
  end
`else
  // no cache storage: every accept goes to RAM
  assign w_hit  = (ICACHE_INDEX_W < 0);
  assign w_line = 32'h0;
`endif

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state, PC-register throttle and byte request
  always_comb begin
    w_state_nxt = r_state;
    stall0      = (r_state != IDLE) | (inst_valid_o & stall_in);
    ram_req_o   = 1'b0;
    ram_addr_o  = 32'h0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (sending && !br && !stall0) begin
          w_accept = 1'b1;
          if (!w_hit) w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        ram_req_o  = ~r_issue_cnt[2];
        ram_addr_o = ram_req_o ? (r_base + {29'h0, r_issue_cnt}) : 32'h0;
        w_complete = r_rd_pending && (r_recv_cnt == 2'd3);
        if (w_complete) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (br) w_state_nxt = IDLE;
  end

  // fetch counters, byte assembly and IF/ID output register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base       <= 32'h0;
      r_issue_cnt  <= 3'd0;
      r_recv_cnt   <= 2'd0;
      r_rd_pending <= 1'b0;
      r_word       <= 24'h0;
      inst_valid_o <= 1'b0;
      inst_o       <= 32'h0;
      inst_pc_o    <= 32'h0;
    end else if (br) begin
      r_issue_cnt  <= 3'd0;
      r_recv_cnt   <= 2'd0;
      r_rd_pending <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      if (w_accept && !w_hit) begin
        r_base       <= pc_i;
        r_issue_cnt  <= 3'd0;
        r_recv_cnt   <= 2'd0;
        r_rd_pending <= 1'b0;
      end else if (r_state == FETCH) begin
        if (w_grant) r_issue_cnt <= r_issue_cnt + 3'd1;
        r_rd_pending <= w_grant;
        if (r_rd_pending) begin
          case (r_recv_cnt)
            2'd0:    r_word[7:0]   <= ram_data_i;
            2'd1:    r_word[15:8]  <= ram_data_i;
            2'd2:    r_word[23:16] <= ram_data_i;
            default: r_word        <= r_word;
          endcase
          r_recv_cnt <= r_recv_cnt + 2'd1;
        end
      end
      if (w_complete) begin
        inst_valid_o <= 1'b1;
        inst_o       <= {ram_data_i, r_word};
        inst_pc_o    <= r_base;
      end else if (w_accept && w_hit) begin
        inst_valid_o <= 1'b1;
        inst_o       <= w_line;
        inst_pc_o    <= pc_i;
      end else if (!(inst_valid_o && stall_in)) begin
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch (also exercises ICACHE_EN when defined)
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        sending;
  logic [31:0] pc_i;
  logic        br;
  logic        stall0;
  logic        stall_in;
  logic        ram_req_o;
  logic [31:0] ram_addr_o;
  logic        mem_grant;
  logic [7:0]  ram_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  always #5 clock = ~clock;

  inst_fetch dut (
    .clock(clock), .reset(reset), .sending(sending), .pc_i(pc_i), .br(br),
    .stall0(stall0), .stall_in(stall_in), .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o),
    .mem_grant(mem_grant), .ram_data_i(ram_data_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];

  // transaction-level reference: PC register, one outstanding word fetch, output slot
  logic [31:0] m_pc;
  bit          m_busy;
  logic [31:0] m_fpc;
  int          m_ngrant;
  int          m_recv;
  bit          m_pend;
  bit          m_ov;
  logic [31:0] m_opc;
  logic [31:0] m_oinst;
  bit          d_valid;
  logic [7:0]  d_byte;
`ifdef ICACHE_EN
  bit          c_v [64];
  logic [31:0] c_pc [64];
  logic [31:0] c_w [64];
`endif

  typedef struct {
    logic [31:0] pc;
    int          gap_byte;
    int          gap_len;
    int          exp_n;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      b = a + k;
      w[8*k +: 8] = mem[b[9:0]];
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_busy = 0; m_fpc = 32'h0; m_ngrant = 0; m_recv = 0; m_pend = 0;
    m_ov = 0; m_opc = 32'h0; m_oinst = 32'h0; d_valid = 0; d_byte = 8'h0;
`ifdef ICACHE_EN
    for (int i = 0; i < 64; i++) c_v[i] = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1; sending = 0; br = 0; stall_in = 0; mem_grant = 0; pc_i = 32'h0; ram_data_i = 8'h0;
    repeat (2) @(negedge clock);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", inst_pc_o, 0);
    chk("rst_req", ram_req_o, 0);
    chk("rst_stall0", stall0, 0);
    reset = 0; sending = 1;
    model_reset();
  endtask

  // one clock cycle: check registered outputs, drive inputs, check combinational outputs, advance model
  task automatic cycle(input bit g, input bit si, input bit b, input logic [31:0] t);
    bit          exp_stall;
    bit          exp_req;
    bit          compl;
    logic [31:0] exp_addr;
    int          idx;
    chk("inst_valid_o", inst_valid_o, m_ov);
    if (m_ov) begin
      chk("inst_o", inst_o, m_oinst);
      chk("inst_pc_o", inst_pc_o, m_opc);
    end
    pc_i = m_pc; mem_grant = g; stall_in = si; br = b;
    ram_data_i = d_valid ? d_byte : 8'($urandom);
    #1;
    exp_stall = m_busy || (m_ov && si);
    exp_req   = m_busy && (m_ngrant < 4);
    exp_addr  = m_fpc + m_ngrant;
    chk("stall0", stall0, exp_stall);
    chk("ram_req_o", ram_req_o, exp_req);
    if (exp_req) chk("ram_addr_o", ram_addr_o, exp_addr);
    d_valid = ram_req_o && g;
    if (d_valid) d_byte = mem[ram_addr_o[9:0]];
    if (b) begin
      m_busy = 0; m_ngrant = 0; m_recv = 0; m_pend = 0; m_ov = 0; m_pc = t;
    end else begin
      compl = m_busy && m_pend && (m_recv == 3);
      if (m_busy) begin
        if (m_pend) m_recv++;
        m_pend = exp_req && g;
        if (m_pend) m_ngrant++;
      end
      if (compl) begin
        m_ov = 1; m_oinst = word_at(m_fpc); m_opc = m_fpc; m_busy = 0;
`ifdef ICACHE_EN
        idx = int'(m_fpc[7:2]);
        c_v[idx] = 1; c_pc[idx] = m_fpc; c_w[idx] = m_oinst;
`endif
      end else if (!(m_ov && si)) begin
        m_ov = 0;
      end
      if (!exp_stall && sending) begin
        idx = int'(m_pc[7:2]);
`ifdef ICACHE_EN
        if (c_v[idx] && c_pc[idx][31:2] == m_pc[31:2]) begin
          m_ov = 1; m_oinst = c_w[idx]; m_opc = m_pc;
        end else
`endif
        begin
          m_busy = 1; m_fpc = m_pc; m_ngrant = 0; m_recv = 0; m_pend = 0;
        end
      end
      if (!exp_stall) m_pc = m_pc + 4;
    end
    @(negedge clock);
  endtask

  // run until an instruction is presented, withholding grant for gap_len cycles on byte gap_byte
  task automatic fetch_wait(input int gap_byte, input int gap_len, output int n);
    int left;
    bit g;
    n = 0;
    left = gap_len;
    while (inst_valid_o !== 1'b1 && n < 40) begin
      g = 1;
      if (m_busy && m_ngrant == gap_byte && left > 0) begin
        g = 0;
        left--;
      end
      cycle(g, 0, 0, 32'h0);
      n++;
    end
    chk("wait_bounded", n < 40, 1);
  endtask

  int          n;
  int          cnt;
  int          at [3];
  logic [31:0] pcs [3];
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  initial begin
    vecs[0] = '{pc: 32'h0000_0000, gap_byte: 0, gap_len: 0, exp_n: 5};
    vecs[1] = '{pc: 32'h0000_0040, gap_byte: 2, gap_len: 3, exp_n: 8};
    vecs[2] = '{pc: 32'h0000_0010, gap_byte: 0, gap_len: 2, exp_n: 7};
    vecs[3] = '{pc: 32'h0000_0200, gap_byte: 3, gap_len: 1, exp_n: 6};
    vecs[4] = '{pc: 32'hFFFF_FFFE, gap_byte: 1, gap_len: 0, exp_n: 5};

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    // first fetch from reset
    do_reset();
    cycle(1, 0, 0, 32'h0);
    fetch_wait(0, 0, n);
    chk("t1_latency", n, 5);
    chk("t1_inst", inst_o, 32'h0010_0513);
    chk("t1_pc", inst_pc_o, 32'h0);

    // latency and grant-gap table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cycle(0, 0, 1, vecs[v].pc);
      cycle(1, 0, 0, 32'h0);
      fetch_wait(vecs[v].gap_byte, vecs[v].gap_len, n);
      chk("tbl_latency", n, vecs[v].exp_n);
      chk("tbl_inst", inst_o, word_at(vecs[v].pc));
      chk("tbl_pc", inst_pc_o, vecs[v].pc);
    end

    // sequential stream 0, 4, 8
    do_reset();
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      if (inst_valid_o === 1'b1) begin
        if (cnt < 3) begin at[cnt] = i; pcs[cnt] = inst_pc_o; end
        cnt++;
      end
      cycle(1, 0, 0, 32'h0);
    end
    chk("seq_count", cnt, 3);
    chk("seq_pc0", pcs[0], 32'h0);
    chk("seq_pc1", pcs[1], 32'h4);
    chk("seq_pc2", pcs[2], 32'h8);
    chk("seq_gap1", at[1] - at[0], 6);
    chk("seq_gap2", at[2] - at[1], 6);

    // redirect after byte 1 received, byte 2 in flight
    do_reset();
    cycle(0, 0, 1, 32'h20);
    cycle(1, 0, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 1, 32'h100);
    chk("br_no_output", inst_valid_o, 0);
    cycle(1, 0, 0, 32'h0);
    fetch_wait(0, 0, n);
    chk("br_latency", n, 5);
    chk("br_pc", inst_pc_o, 32'h100);
    chk("br_inst", inst_o, word_at(32'h100));

    // downstream stall holds the output; redirect during hold clears it
    hold_inst = inst_o;
    hold_pc   = inst_pc_o;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 0, 32'h0);
      chk("hold_valid", inst_valid_o, 1);
      chk("hold_inst", inst_o, hold_inst);
      chk("hold_pc", inst_pc_o, hold_pc);
    end
    chk("hold_stall0", stall0, 1);
    chk("hold_no_req", ram_req_o, 0);
    cycle(1, 1, 1, 32'h180);
    chk("hold_br_clears", inst_valid_o, 0);

    // redirect on the completion edge drops the word
    do_reset();
    cycle(0, 0, 1, 32'h2C0);
    cycle(1, 0, 0, 32'h0);
    repeat (4) cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 1, 32'h300);
    chk("br_beats_compl", inst_valid_o, 0);
    cycle(1, 0, 0, 32'h0);
    fetch_wait(0, 0, n);
    chk("after_drop_pc", inst_pc_o, 32'h300);

    // reset in the middle of a fetch
    do_reset();
    cycle(0, 0, 1, 32'h80);
    cycle(1, 0, 0, 32'h0);
    repeat (2) cycle(1, 0, 0, 32'h0);
    do_reset();
    cycle(1, 0, 0, 32'h0);
    fetch_wait(0, 0, n);
    chk("rst_mid_latency", n, 5);
    chk("rst_mid_pc", inst_pc_o, 32'h0);

`ifdef ICACHE_EN
    // revisit hits; reset invalidates
    do_reset();
    cycle(0, 0, 1, 32'h40);
    cycle(1, 0, 0, 32'h0);
    fetch_wait(0, 0, n);
    cycle(1, 0, 1, 32'h40);
    cycle(1, 0, 0, 32'h0);
    chk("hit_valid", inst_valid_o, 1);
    chk("hit_pc", inst_pc_o, 32'h40);
    chk("hit_inst", inst_o, word_at(32'h40));
    chk("hit_no_req", ram_req_o, 0);
    do_reset();
    cycle(0, 0, 1, 32'h40);
    cycle(1, 0, 0, 32'h0);
    chk("miss_after_rst", ram_req_o, 1);
`endif

    // randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 20) == 0,
            {22'h0, 8'($urandom), 2'b00});
    end
    cycle(1, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
